cpu_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit accumulator CPU. It fetches 16-bit instructions from the instruction ROM, drives the registered ALU with opcode and operands, and captures the ALU's address/data results. It owns registers A and B and the program counter, and runs a req/ack handshake to data memory for loads and stores. It sits between the instruction ROM, the ALU and the data-memory port.

---
 rtl/cpu_sequencer_if.sv | 20 ++
 rtl/cpu_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Data-memory req/ack port of the accumulator CPU sequencer.
// The sequencer is the master; the memory model or controller is the slave.
interface cpu_sequencer_if;
    logic       memReq;
    logic       memWe;
    logic [9:0] memAddr;
    logic [7:0] memWData;
    logic       memAck;
    logic [7:0] memRData;

    modport master (
        output memReq, memWe, memAddr, memWData,
        input  memAck, memRData
    );

    modport slave (
        input  memReq, memWe, memAddr, memWData,
        output memAck, memRData
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit of the 8-bit accumulator CPU: FETCH/EXEC/RESULT/MEM.
// Define ILLEGAL_TRAP_EN to make illegal opcodes enter the terminal TRAP state.
module cpu_sequencer #(
    parameter logic [9:0] PC_RESET = 10'h000
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [9:0]             iAddr,
    input  logic [15:0]            iData,
    output logic [5:0]             aluOpcode,
    output logic [9:0]             aluIn1,
    output logic [9:0]             aluIn2,
    input  logic [9:0]             aluReDir,
    input  logic [9:0]             aluWrDir,
    input  logic [7:0]             aluWrData,
    cpu_sequencer_if.master        mem,
    output logic [7:0]             regA,
    output logic [7:0]             regB,
    output logic                   halt,
    output logic [9:0]             trapPc
);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_LDCA = 6'h01;
    localparam logic [5:0] OP_LDCB = 6'h02;
    localparam logic [5:0] OP_LDA  = 6'h03;
    localparam logic [5:0] OP_LDB  = 6'h04;
    localparam logic [5:0] OP_STA  = 6'h05;
    localparam logic [5:0] OP_STB  = 6'h06;
    localparam logic [5:0] OP_ADDA = 6'h07;
    localparam logic [5:0] OP_ADDB = 6'h08;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_RESULT,
        ST_MEM
`ifdef ILLEGAL_TRAP_EN
        , ST_TRAP
`endif
    } state_t;

    state_t     r_state;
    logic [9:0] r_pc;
    logic [5:0] r_ir_op;
    logic [7:0] r_ir_imm;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [5:0] r_alu_opcode;
    logic [9:0] r_alu_in1;
    logic [9:0] r_alu_in2;
    logic       r_mem_req;
    logic       r_mem_we;
    logic [9:0] r_mem_addr;
    logic [7:0] r_mem_wdata;

    logic [5:0] w_op;
    logic [9:0] w_operand;

    assign w_op      = iData[15:10];
    assign w_operand = iData[9:0];

`ifdef ILLEGAL_TRAP_EN
    logic       r_halt;
    logic [9:0] r_trap_pc;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_NOP, OP_LDCA, OP_LDCB, OP_LDA, OP_LDB,
            OP_STA, OP_STB, OP_ADDA, OP_ADDB: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction
`endif

    // ALU inputs are registered at the FETCH edge so they are stable for
    // exactly the EXEC cycle; A and B cannot change between FETCH and EXEC.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it sits inside the clocked block
        // and every state element below uses non-blocking assignment.
        if (!reset) begin
            r_state      <= ST_FETCH;
            r_pc         <= PC_RESET;
            r_ir_op      <= OP_NOP;
            r_ir_imm     <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_alu_opcode <= OP_NOP;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
`ifdef ILLEGAL_TRAP_EN
            r_halt       <= 1'b0;
            r_trap_pc    <= '0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_ir_op      <= w_op;
                    r_ir_imm     <= w_operand[7:0];
                    r_pc         <= r_pc + 10'd1;
                    r_alu_opcode <= w_op;
                    r_alu_in1    <= '0;
                    r_alu_in2    <= '0;
                    case (w_op)
                        OP_LDA, OP_LDB: r_alu_in1 <= w_operand;
                        OP_STA: begin
                            r_alu_in1 <= w_operand;
                            r_alu_in2 <= {2'b00, r_a};
                        end
                        OP_STB: begin
                            r_alu_in1 <= {2'b00, r_b};
                            r_alu_in2 <= w_operand;
                        end
                        OP_ADDA, OP_ADDB: begin
                            r_alu_in1 <= {2'b00, r_a};
                            r_alu_in2 <= {2'b00, r_b};
                        end
                        default: ;
                    endcase
                    r_state <= ST_EXEC;
                end

                ST_EXEC: begin
                    r_alu_opcode <= OP_NOP;
                    r_alu_in1    <= '0;
                    r_alu_in2    <= '0;
                    r_state      <= ST_RESULT;
`ifdef ILLEGAL_TRAP_EN
                    if (!is_legal(r_ir_op)) begin
                        r_state   <= ST_TRAP;
                        r_halt    <= 1'b1;
                        r_trap_pc <= r_pc - 10'd1;
                    end
`endif
                end

                ST_RESULT: begin
                    r_state <= ST_FETCH;
                    case (r_ir_op)
                        OP_LDCA: r_a <= r_ir_imm;
                        OP_LDCB: r_b <= r_ir_imm;
                        OP_ADDA: r_a <= aluWrData;
                        OP_ADDB: r_b <= aluWrData;
                        OP_LDA, OP_LDB: begin
                            r_mem_addr <= aluReDir;
                            r_mem_we   <= 1'b0;
                            r_mem_req  <= 1'b1;
                            r_state    <= ST_MEM;
                        end
                        OP_STA, OP_STB: begin
                            r_mem_addr  <= aluWrDir;
                            r_mem_wdata <= aluWrData;
                            r_mem_we    <= 1'b1;
                            r_mem_req   <= 1'b1;
                            r_state     <= ST_MEM;
                        end
                        default: ;
                    endcase
                end

                ST_MEM: begin
                    if (mem.memAck) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_FETCH;
                        if (!r_mem_we) begin
                            if (r_ir_op == OP_LDA) r_a <= mem.memRData;
                            else                   r_b <= mem.memRData;
                        end
                    end
                end

`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: r_state <= ST_TRAP;
`endif

                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign iAddr        = r_pc;
    assign aluOpcode    = r_alu_opcode;
    assign aluIn1       = r_alu_in1;
    assign aluIn2       = r_alu_in2;
    assign regA         = r_a;
    assign regB         = r_b;
    assign mem.memReq   = r_mem_req;
    assign mem.memWe    = r_mem_we;
    assign mem.memAddr  = r_mem_addr;
    assign mem.memWData = r_mem_wdata;

`ifdef ILLEGAL_TRAP_EN
    assign halt   = r_halt;
    assign trapPc = r_trap_pc;
`else
    assign halt   = 1'b0;
    assign trapPc = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: ROM, registered ALU and data memory are
// modelled here; expectations are queued by the stimulus and popped by monitors.
module tb_cpu_sequencer;

    localparam logic [5:0] NOP  = 6'h00;
    localparam logic [5:0] LDCA = 6'h01;
    localparam logic [5:0] LDCB = 6'h02;
    localparam logic [5:0] LDA  = 6'h03;
    localparam logic [5:0] LDB  = 6'h04;
    localparam logic [5:0] STA  = 6'h05;
    localparam logic [5:0] STB  = 6'h06;
    localparam logic [5:0] ADDA = 6'h07;
    localparam logic [5:0] ADDB = 6'h08;

    typedef enum int {S_REGA, S_REGB, S_PC, S_OPC, S_IN1, S_IN2,
                      S_HALT, S_TRAPPC, S_MEMREQ, S_MEMWE, S_MEMADDR, S_MEMWDATA} sig_e;

    typedef struct {
        string       name;
        sig_e        sel;
        logic [31:0] exp;
    } sig_exp_t;

    typedef struct {
        logic [9:0] addr;
        logic       we;
        logic [7:0] wdata;
        bit         chk_wdata;
        int         len;
    } mem_exp_t;

    logic        clk;
    logic        reset;
    logic [9:0]  iAddr;
    logic [15:0] iData;
    logic [5:0]  aluOpcode;
    logic [9:0]  aluIn1, aluIn2;
    logic [9:0]  aluReDir, aluWrDir;
    logic [7:0]  aluWrData;
    logic [7:0]  regA, regB;
    logic        halt;
    logic [9:0]  trapPc;

    cpu_sequencer_if mem_if ();

    cpu_sequencer #(.PC_RESET(10'h000)) dut (
        .clk       (clk),
        .reset     (reset),
        .iAddr     (iAddr),
        .iData     (iData),
        .aluOpcode (aluOpcode),
        .aluIn1    (aluIn1),
        .aluIn2    (aluIn2),
        .aluReDir  (aluReDir),
        .aluWrDir  (aluWrDir),
        .aluWrData (aluWrData),
        .mem       (mem_if),
        .regA      (regA),
        .regB      (regB),
        .halt      (halt),
        .trapPc    (trapPc)
    );

    int n_total = 0;
    int n_bad   = 0;

    sig_exp_t sig_q[$];
    mem_exp_t mem_q[$];

    logic [15:0] rom [0:1023];
    int          ack_delay = 0;
    int          req_cnt   = 0;
    logic        auto_ack  = 1'b0;
    logic        late_ack  = 1'b0;
    logic [7:0]  rd_data   = 8'h00;
    bit          after_ack = 1'b0;
    int          req_len   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign iData           = rom[iAddr];
    assign mem_if.memAck   = auto_ack | late_ack;
    assign mem_if.memRData = rd_data;

    // Registered ALU: results appear the cycle after the opcode is presented.
    always @(posedge clk) begin
        case (aluOpcode)
            LDA, LDB: aluReDir <= aluIn1;
            STA: begin
                aluWrDir  <= aluIn1;
                aluWrData <= aluIn2[7:0];
            end
            STB: begin
                aluWrDir  <= aluIn2;
                aluWrData <= aluIn1[7:0];
            end
            ADDA, ADDB: aluWrData <= aluIn1[7:0] + aluIn2[7:0];
            default: ;
        endcase
    end

    // Memory responder: acks in the (ack_delay+1)-th cycle of a request.
    always @(negedge clk) begin
        if (mem_if.memReq) begin
            auto_ack = (req_cnt == ack_delay);
            req_cnt  = req_cnt + 1;
        end else begin
            auto_ack = 1'b0;
            req_cnt  = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            S_REGA:     return {24'b0, regA};
            S_REGB:     return {24'b0, regB};
            S_PC:       return {22'b0, iAddr};
            S_OPC:      return {26'b0, aluOpcode};
            S_IN1:      return {22'b0, aluIn1};
            S_IN2:      return {22'b0, aluIn2};
            S_HALT:     return {31'b0, halt};
            S_TRAPPC:   return {22'b0, trapPc};
            S_MEMREQ:   return {31'b0, mem_if.memReq};
            S_MEMWE:    return {31'b0, mem_if.memWe};
            S_MEMADDR:  return {22'b0, mem_if.memAddr};
            S_MEMWDATA: return {24'b0, mem_if.memWData};
            default:    return '1;
        endcase
    endfunction

    task automatic expect_sig(input string name, input sig_e sel, input logic [31:0] exp);
        sig_exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sig_q.push_back(e);
    endtask

    task automatic expect_mem(input logic [9:0] addr, input logic we, input logic [7:0] wdata,
                              input bit chk_wdata, input int len);
        mem_exp_t m;
        m.addr      = addr;
        m.we        = we;
        m.wdata     = wdata;
        m.chk_wdata = chk_wdata;
        m.len       = len;
        mem_q.push_back(m);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_rom_nop();
        for (int i = 0; i < 1024; i++) rom[i] = {NOP, 10'h000};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    function automatic logic [15:0] ins(input logic [5:0] op, input logic [9:0] opr);
        return {op, opr};
    endfunction

    // Signal monitor: compares every queued expectation 1 ns after a falling edge.
    initial begin
        sig_exp_t e;
        forever begin
            @(negedge clk);
            #1;
            while (sig_q.size() > 0) begin
                e = sig_q.pop_front();
                check(e.name, sample(e.sel), e.exp);
            end
        end
    end

    // Memory monitor: scores each completed req/ack transaction against the queue.
    initial begin
        mem_exp_t m;
        forever begin
            @(negedge clk);
            #1;
            if (after_ack) check("memReq_drop_after_ack", {31'b0, mem_if.memReq}, 32'h0);
            after_ack = 1'b0;
            if (mem_if.memReq) begin
                req_len++;
                if (mem_if.memAck) begin
                    if (mem_q.size() == 0) begin
                        n_total++;
                        n_bad++;
                        $display("FAIL mem_unexpected: txn at addr 0x%0h, none expected",
                                 mem_if.memAddr);
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_addr",  {22'b0, mem_if.memAddr}, {22'b0, m.addr});
                        check("mem_we",    {31'b0, mem_if.memWe},   {31'b0, m.we});
                        if (m.chk_wdata)
                            check("mem_wdata", {24'b0, mem_if.memWData}, {24'b0, m.wdata});
                        check("mem_req_cycles", req_len, m.len);
                    end
                    after_ack = 1'b1;
                end
            end else begin
                req_len = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        late_ack = 1'b0;

        // Program 1: constants, add, store, load, illegal opcode at address 5.
        load_rom_nop();
        rom[0] = ins(LDCA, 10'h05A);
        rom[1] = ins(LDCB, 10'h003);
        rom[2] = ins(ADDA, 10'h000);
        rom[3] = ins(STA,  10'h120);
        rom[4] = ins(LDB,  10'h3FF);
        rom[5] = ins(6'h3F, 10'h000);
        ack_delay = 2;
        rd_data   = 8'h00;
        step(2);
        expect_sig("rst_regA",     S_REGA,     32'h0);
        expect_sig("rst_regB",     S_REGB,     32'h0);
        expect_sig("rst_pc",       S_PC,       32'h0);
        expect_sig("rst_opcode",   S_OPC,      {26'b0, NOP});
        expect_sig("rst_in1",      S_IN1,      32'h0);
        expect_sig("rst_in2",      S_IN2,      32'h0);
        expect_sig("rst_memReq",   S_MEMREQ,   32'h0);
        expect_sig("rst_memWe",    S_MEMWE,    32'h0);
        expect_sig("rst_memAddr",  S_MEMADDR,  32'h0);
        expect_sig("rst_memWData", S_MEMWDATA, 32'h0);
        expect_sig("rst_halt",     S_HALT,     32'h0);
        expect_sig("rst_trapPc",   S_TRAPPC,   32'h0);
        reset = 1'b1;

        step(1);
        expect_sig("ldca_exec_opcode", S_OPC, {26'b0, LDCA});
        expect_sig("ldca_exec_in1",    S_IN1, 32'h0);
        expect_sig("ldca_exec_pc",     S_PC,  32'h1);
        step(8);
        expect_sig("prog1_regA",   S_REGA, 32'h5D);
        expect_sig("prog1_regB",   S_REGB, 32'h03);
        expect_sig("prog1_pc",     S_PC,   32'h3);
        expect_sig("idle_opcode",  S_OPC,  {26'b0, NOP});
        expect_sig("idle_in1",     S_IN1,  32'h0);
        expect_sig("idle_in2",     S_IN2,  32'h0);

        expect_mem(10'h120, 1'b1, 8'h5D, 1'b1, 3);
        step(1);
        expect_sig("sta_exec_opcode", S_OPC, {26'b0, STA});
        expect_sig("sta_exec_in1",    S_IN1, 32'h120);
        expect_sig("sta_exec_in2",    S_IN2, 32'h05D);
        step(5);
        expect_sig("sta_done_pc",   S_PC,   32'h4);
        expect_sig("sta_done_regA", S_REGA, 32'h5D);

        ack_delay = 0;
        rd_data   = 8'hC4;
        expect_mem(10'h3FF, 1'b0, 8'h00, 1'b0, 1);
        step(4);
        expect_sig("ldb_regB", S_REGB, 32'hC4);
        expect_sig("ldb_regA", S_REGA, 32'h5D);
        expect_sig("ldb_pc",   S_PC,   32'h5);

`ifdef ILLEGAL_TRAP_EN
        step(3);
        expect_sig("trap_halt",   S_HALT,   32'h1);
        expect_sig("trap_pc_reg", S_TRAPPC, 32'h5);
        expect_sig("trap_memReq", S_MEMREQ, 32'h0);
        expect_sig("trap_pc",     S_PC,     32'h6);
        step(6);
        expect_sig("trap_hold_halt",   S_HALT,   32'h1);
        expect_sig("trap_hold_pc",     S_PC,     32'h6);
        expect_sig("trap_hold_memReq", S_MEMREQ, 32'h0);
        expect_sig("trap_hold_regA",   S_REGA,   32'h5D);
        expect_sig("trap_hold_regB",   S_REGB,   32'hC4);
`else
        step(3);
        expect_sig("illegal_nop_pc",     S_PC,     32'h6);
        expect_sig("illegal_nop_halt",   S_HALT,   32'h0);
        expect_sig("illegal_nop_trapPc", S_TRAPPC, 32'h0);
        expect_sig("illegal_nop_regA",   S_REGA,   32'h5D);
        expect_sig("illegal_nop_regB",   S_REGB,   32'hC4);
        step(3);
        expect_sig("after_illegal_pc", S_PC, 32'h7);
`endif

        // Program 2: 8-bit add overflow, ADDB, STB, LDA.
        step(1);
        load_rom_nop();
        rom[0] = ins(LDCA, 10'h0F0);
        rom[1] = ins(LDCB, 10'h020);
        rom[2] = ins(ADDA, 10'h000);
        rom[3] = ins(ADDB, 10'h000);
        rom[4] = ins(STB,  10'h0AB);
        rom[5] = ins(LDA,  10'h055);
        ack_delay = 1;
        do_reset();
        step(9);
        expect_sig("adda_wrap_regA", S_REGA, 32'h10);
        expect_sig("adda_wrap_regB", S_REGB, 32'h20);
        expect_sig("adda_wrap_pc",   S_PC,   32'h3);
        step(3);
        expect_sig("addb_regB", S_REGB, 32'h30);
        expect_sig("addb_regA", S_REGA, 32'h10);

        expect_mem(10'h0AB, 1'b1, 8'h30, 1'b1, 2);
        step(1);
        expect_sig("stb_exec_opcode", S_OPC, {26'b0, STB});
        expect_sig("stb_exec_in1",    S_IN1, 32'h030);
        expect_sig("stb_exec_in2",    S_IN2, 32'h0AB);
        step(4);
        expect_sig("stb_done_pc", S_PC, 32'h5);

        ack_delay = 0;
        rd_data   = 8'h77;
        expect_mem(10'h055, 1'b0, 8'h00, 1'b0, 1);
        step(1);
        expect_sig("lda_exec_opcode", S_OPC, {26'b0, LDA});
        expect_sig("lda_exec_in1",    S_IN1, 32'h055);
        expect_sig("lda_exec_in2",    S_IN2, 32'h000);
        step(3);
        expect_sig("lda_regA", S_REGA, 32'h77);
        expect_sig("lda_regB", S_REGB, 32'h30);
        expect_sig("lda_pc",   S_PC,   32'h6);

        // Program 3: all NOP, PC walks to 1023 and wraps to 0.
        step(1);
        load_rom_nop();
        do_reset();
        step(3 * 1023);
        expect_sig("pc_at_top", S_PC, 32'h3FF);
        step(3);
        expect_sig("pc_wrap", S_PC, 32'h000);

        // Program 4: reset while LDA waits in MEM, then a late ack.
        step(1);
        load_rom_nop();
        rom[0] = ins(LDCA, 10'h042);
        rom[1] = ins(LDA,  10'h055);
        ack_delay = 1000;
        rd_data   = 8'h99;
        do_reset();
        step(6);
        expect_sig("mem_wait_memReq", S_MEMREQ, 32'h1);
        expect_sig("mem_wait_regA",   S_REGA,   32'h42);
        expect_sig("mem_wait_pc",     S_PC,     32'h2);
        reset = 1'b0;
        step(1);
        expect_sig("midrst_memReq", S_MEMREQ, 32'h0);
        expect_sig("midrst_regA",   S_REGA,   32'h0);
        expect_sig("midrst_pc",     S_PC,     32'h0);
        reset    = 1'b1;
        late_ack = 1'b1;
        step(1);
        late_ack = 1'b0;
        expect_sig("late_ack_regA",   S_REGA,   32'h0);
        expect_sig("late_ack_memReq", S_MEMREQ, 32'h0);

        step(2);
        check("sig_queue_drained", sig_q.size(), 32'h0);
        check("mem_queue_drained", mem_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
